// File: rtl/master_slave_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// master_slave_arbiter_types
//
// Purpose : shared types and constants for the two-requester round-robin
//           accumulator (master_slave_arbiter) and its picker (rr_picker2).
// Contents:
//   section_e       - FSM sections IDLE / COMPUTE / SEND
//   req_idx_t       - requester index (0 or 1)
//   SAT_*           - width-independent building blocks for the signed
//                     saturation limits; the top assembles them at DATA_W
//   ovf_kind()      - signed-add overflow classifier from the three sign bits
// ---------------------------------------------------------------------------
package master_slave_arbiter_types;

  typedef enum logic [1:0] {
    SEC_IDLE    = 2'd0,
    SEC_COMPUTE = 2'd1,
    SEC_SEND    = 2'd2
  } section_e;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  // Signed max is 0 followed by all ones; signed min is 1 followed by zeros.
  localparam logic SAT_MAX_MSB  = 1'b0;
  localparam logic SAT_MAX_REST = 1'b1;
  localparam logic SAT_MIN_MSB  = 1'b1;
  localparam logic SAT_MIN_REST = 1'b0;

  // Classify a two's-complement addition: bit1 = positive overflow
  // (two non-negative operands gave a negative result), bit0 = negative
  // overflow (two negative operands gave a non-negative result).
  function automatic logic [1:0] ovf_kind(input logic a_msb,
                                          input logic b_msb,
                                          input logic s_msb);
    logic [1:0] kind;
    kind = 2'b00;
    if (!a_msb && !b_msb && s_msb) begin
      kind = 2'b10;
    end else if (a_msb && b_msb && !s_msb) begin
      kind = 2'b01;
    end else begin
      kind = 2'b00;
    end
    return kind;
  endfunction

endpackage

// File: rtl/master_slave_arbiter_rr_picker2.sv
// ---------------------------------------------------------------------------
// rr_picker2
//
// Purpose : combinational two-way round-robin select. When both requesters
//           are asking, the one that was NOT granted last wins; otherwise
//           the single asking requester wins.
// Ports   :
//   sync0, sync1  in  request flags of requester 0 / 1
//   last_grant    in  index of the most recently granted requester
//   valid         out at least one request present
//   idx           out index of the selected requester (REQ0 when !valid)
// ---------------------------------------------------------------------------
module rr_picker2
  import master_slave_arbiter_types::*;
(
  input  logic     sync0,
  input  logic     sync1,
  input  req_idx_t last_grant,
  output logic     valid,
  output req_idx_t idx
);

  // Round-robin selection between the two request flags.
  always_comb begin
    valid = sync0 | sync1;
    idx   = REQ0;
    if (sync0 && sync1) begin
      idx = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (sync1) begin
      idx = REQ1;
    end else begin
      idx = REQ0;
    end
  end

endmodule

// File: rtl/master_slave_arbiter.sv
// ---------------------------------------------------------------------------
// master_slave_arbiter
//
// Purpose : shares one signed accumulator and one blocking output port
//           between two requesters. A granted requester's value is added to
//           the shared register and the sum is offered on out_data with an
//           out_notify / out_sync handshake. Sections: IDLE -> COMPUTE ->
//           SEND -> IDLE, so grants are at least three cycles apart.
//
// Parameters:
//   DATA_W          data / accumulator width
//   SATURATE        1 = clamp to signed max/min, 0 = two's-complement wrap
//   TIMEOUT_CYCLES  SEND cycles without out_sync before giving up
//                   (only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk                  in   rising-edge clock
//   rst                  in   asynchronous active-low reset
//   req0_data/req0_sync  in   requester 0 value (signed) and valid
//   req1_data/req1_sync  in   requester 1 value (signed) and valid
//   grant0/grant1        out  one-cycle acknowledge, never both high
//   out_data             out  accumulated result
//   out_notify           out  out_data valid, held until accepted
//   out_sync             in   consumer ready
//   busy                 out  high whenever the section is not IDLE
//   err                  out  sticky handshake-timeout flag
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, SEND abandons the handshake after
//                   TIMEOUT_CYCLES cycles and sets err; when undefined SEND
//                   waits forever and err is tied low.
// ---------------------------------------------------------------------------
module master_slave_arbiter
  import master_slave_arbiter_types::*;
#(
  parameter int DATA_W         = 32,
  parameter int SATURATE       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_sync,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_sync,
  output logic              grant0,
  output logic              grant1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_notify,
  input  logic              out_sync,
  output logic              busy,
  output logic              err
);

  localparam logic [DATA_W-1:0] SAT_MAX = {SAT_MAX_MSB, {(DATA_W-1){SAT_MAX_REST}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {SAT_MIN_MSB, {(DATA_W-1){SAT_MIN_REST}}};

  section_e          state_q,      state_d;
  logic [DATA_W-1:0] shared_q,     shared_d;
  logic [DATA_W-1:0] held_q,       held_d;
  req_idx_t          last_grant_q, last_grant_d;
  logic              grant0_q,     grant0_d;
  logic              grant1_q,     grant1_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic              out_notify_q, out_notify_d;
  logic              busy_q,       busy_d;

  logic              pick_valid;
  req_idx_t          pick_idx;
  logic [DATA_W-1:0] sum_wrap;
  logic [1:0]        sum_ovf;
  logic [DATA_W-1:0] sum_res;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_picker2 u_picker (
    .sync0      (req0_sync),
    .sync1      (req1_sync),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Signed accumulate with optional clamping; overflow is judged from the
  // operand and wrapped-result sign bits.
  always_comb begin
    sum_wrap = shared_q + held_q;
    sum_ovf  = ovf_kind(shared_q[DATA_W-1], held_q[DATA_W-1], sum_wrap[DATA_W-1]);
    sum_res  = sum_wrap;
    if ((SATURATE != 0) && sum_ovf[1]) begin
      sum_res = SAT_MAX;
    end else if ((SATURATE != 0) && sum_ovf[0]) begin
      sum_res = SAT_MIN;
    end else begin
      sum_res = sum_wrap;
    end
  end

  // Next-section and next-output logic.
  always_comb begin
    state_d      = state_q;
    shared_d     = shared_q;
    held_d       = held_q;
    last_grant_d = last_grant_q;
    grant0_d     = 1'b0;
    grant1_d     = 1'b0;
    out_data_d   = out_data_q;
    out_notify_d = out_notify_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    case (state_q)
      SEC_IDLE: begin
        if (pick_valid) begin
          held_d       = (pick_idx == REQ1) ? req1_data : req0_data;
          grant0_d     = (pick_idx == REQ0);
          grant1_d     = (pick_idx == REQ1);
          last_grant_d = pick_idx;
          state_d      = SEC_COMPUTE;
        end else begin
          state_d      = SEC_IDLE;
        end
      end
      SEC_COMPUTE: begin
        shared_d     = sum_res;
        out_data_d   = sum_res;
        out_notify_d = 1'b1;
        state_d      = SEC_SEND;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = {CNT_W{1'b0}};
`endif
      end
      SEC_SEND: begin
        if (out_sync) begin
          out_notify_d = 1'b0;
          state_d      = SEC_IDLE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          // This is the TIMEOUT_CYCLES-th stalled SEND cycle: give up.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            out_notify_d = 1'b0;
            err_d        = 1'b1;
            state_d      = SEC_IDLE;
          end else begin
            cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d      = SEC_SEND;
          end
`else
          state_d      = SEC_SEND;
`endif
        end
      end
      default: begin
        out_notify_d = 1'b0;
        state_d      = SEC_IDLE;
      end
    endcase

    // busy is registered from the next section so it lines up with state_q.
    busy_d = (state_d != SEC_IDLE);
  end

  // Section, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SEC_IDLE;
      shared_q     <= {DATA_W{1'b0}};
      held_q       <= {DATA_W{1'b0}};
      last_grant_q <= REQ1;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_notify_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shared_q     <= shared_d;
      held_q       <= held_d;
      last_grant_q <= last_grant_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      out_data_q   <= out_data_d;
      out_notify_q <= out_notify_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Handshake timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant0     = grant0_q;
  assign grant1     = grant1_q;
  assign out_data   = out_data_q;
  assign out_notify = out_notify_q;
  assign busy       = busy_q;

endmodule
